uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` transmitter between `N` byte-stream requesters (e.g. CPU console, debug monitor, logger). It sits between the requesters and the `uart_tx` `in`/`we`/`ready` port, sequencing one byte at a time. It holds the grant for a whole packet (terminated by `last`), so messages from different sources never interleave on the wire.

## Interface
- `N`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 1024: idle-cycle limit for a stalled packet owner; used only with `UART_ARB_TIMEOUT_EN`.
- `ck`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `req_valid`  in  N  requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_data`  in  8*N  packed bytes, requester 0 in bits [7:0].
- `req_last`  in  N  byte from requester i is the final byte of its packet.
- `req_ack`  out  N  one-cycle pulse: requester i's byte was taken.
- `grant`  out  N  one-hot owner of the transmitter; 0 when idle.
- `busy`  out  1  a grant is held.
- `abort`  out  1  one-cycle pulse when a grant is revoked by timeout.
- `tx_in`  out  8  byte to `uart_tx.in`.
- `tx_we`  out  1  to `uart_tx.we`.
- `tx_ready`  in  1  from `uart_tx.ready`.

## Operation
- Requester rule: hold `req_valid`/`req_data`/`req_last` stable until `req_ack` is seen. Dropping `req_valid` before ack withdraws the byte.
- FSM states: IDLE, LOAD, SEND, WAIT.
- IDLE: if any `req_valid` is set, pick the first set bit scanning upward from `ptr+1` (mod N). Set `grant` one-hot to it, `ptr` to its index, go to LOAD. With none set, stay in IDLE.
- LOAD: if `req_valid[g]` and `tx_ready`:
  - register `tx_in <= byte`, `tx_we <= 1`, `req_ack[g] <= 1`;
  - latch `last_q <= req_last[g]`;
  - go to SEND.
- SEND: `tx_we` and `req_ack` high for exactly this cycle. Next edge: `tx_we <= 0`, `req_ack <= 0`, go to WAIT.
- WAIT: stay while `tx_ready == 0`. When `tx_ready == 1`:
  - if `last_q`, clear `grant` and go to IDLE;
  - else go to LOAD.
- The grant is never changed mid-packet. Other requesters wait regardless of priority.
- `busy` = (state != IDLE).
- Round-robin: after a packet from requester k completes, requester k+1 mod N has highest priority. Reset sets `ptr = N-1`, so requester 0 wins first.
- Simultaneous requests in IDLE are resolved in a single cycle, with no bubble beyond the IDLE cycle.
- Width rules: `ptr` is `$clog2(N)` bits, wrapping at N (not a power of 2). `req_data` byte selection is by `ptr`.

## Timing
- Reset values: `tx_we=0`, `tx_in=8'h00`, `req_ack=0`, `grant=0`, `busy=0`, `abort=0`, state IDLE, `last_q=0`, timeout counter 0, `ptr=N-1`.
- Request to `tx_we` latency: `req_valid` high at edge 0 in IDLE gives grant at edge 1 (LOAD). If `tx_ready`, `tx_we`/`req_ack` are high from edge 2 to edge 3.
- `tx_we` is never high on two consecutive cycles. `uart_tx` drops `ready` on the edge ending SEND, so WAIT always observes at least one low cycle.
- Per-byte overhead beyond the uart frame: 2 cycles (LOAD, SEND) plus WAIT exit.
- Back-to-back packets from the same requester: it re-arbitrates through IDLE and keeps priority only if no other requester is valid.
- Reset mid-operation clears all state asynchronously. A byte already latched by `uart_tx` still completes on the wire. The block issues nothing until `tx_ready` is 1.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - a counter of width `$clog2(TIMEOUT+1)` increments each cycle in LOAD with `req_valid[g]==0`, and clears otherwise;
  - on reaching `TIMEOUT`, `grant` clears, `abort` pulses for 1 cycle, and the FSM returns to IDLE;
  - `ptr` remains at the revoked owner, so the next requester gets priority.
- Not defined: no counter; `abort` is tied 0; a stalled owner holds the grant indefinitely.

## Test plan
- Single requester 0 sends 0x41 with last=1 → `tx_in`=0x41, one `tx_we` pulse 2 cycles after valid, one `req_ack[0]`, `grant` returns to 0 after `tx_ready` rises.
- N=3, all valid simultaneously with 1-byte packets from reset → service order 0,1,2, then 0 again if re-requested; exactly one `tx_we` per byte.
- Requester 1 sends 3-byte packet 0x10,0x11,0x12 (last on third) while requester 0 is valid throughout → bytes contiguous, `grant`=2'b10 held, requester 0 served next.
- `tx_ready` held low 50 cycles in WAIT → no `tx_we`, no `req_ack`, state WAIT until `tx_ready`=1.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=8: owner sends non-last byte then drops valid → `abort` pulses exactly 8 cycles later, `grant`=0, other requester granted next. Without the macro: grant held after 1000 cycles.
- Assert `rst_n`=0 during SEND → `tx_we`, `req_ack`, `grant` go 0 immediately. After release, nothing is issued until `tx_ready`=1.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between N packet requesters; the grant is held for a whole packet.
// Optional stalled-owner timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int N       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic           ck,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ack,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           abort,
    output logic [7:0]     tx_in,
    output logic           tx_we,
    input  logic           tx_ready
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_d, req_ack_d;
    logic [7:0]    tx_in_d;
    logic          tx_we_d;
    logic          last_q, last_d;

    logic [7:0]    sel_byte;
    logic          sel_valid, sel_last;
    logic          found;
    logic [PW-1:0] pick;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    // ptr always holds the index of the current owner while a grant is held.
    always_comb begin
        sel_byte  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q == PW'(i)) begin
                sel_byte  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // First valid requester scanning upward from ptr+1, wrapping at N.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_valid[j] && (j == (int'(ptr_q) + i) % N)) begin
                    found = 1'b1;
                    pick  = PW'(j);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant;
        tx_in_d   = tx_in;
        tx_we_d   = 1'b0;
        req_ack_d = '0;
        last_d    = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = '0;
        abort_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = N'(1) << pick;
                    ptr_d   = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid && tx_ready) begin
                    tx_in_d   = sel_byte;
                    tx_we_d   = 1'b1;
                    req_ack_d = grant;
                    last_d    = sel_last;
                    state_d   = SEND;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!sel_valid) begin
                    // ptr stays on the revoked owner so the next requester wins.
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        grant_d = '0;
                        abort_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N - 1);
            grant   <= '0;
            tx_in   <= 8'h00;
            tx_we   <= 1'b0;
            req_ack <= '0;
            last_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            tx_in   <= tx_in_d;
            tx_we   <= tx_we_d;
            req_ack <= req_ack_d;
            last_q  <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
`endif
        end
    end

endmodule
